// File: rtl/or_16.sv
// or_16: 16-bit bitwise OR with registered result, non-zero flag and
// optional OR-accumulator (compiled in when OR16_ACC_EN is defined).
module or_16 (
    output logic [15:0] out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        acc_clr,
    output logic [15:0] out_q,
    output logic        any_q,
    output logic [15:0] acc
);

    logic [15:0] w_or;
    logic [15:0] r_out_q;
    logic        r_any_q;

    assign w_or = a | b;
    assign out  = w_or;

    // Capture the OR result and its non-zero flag on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= 16'h0000;
            r_any_q <= 1'b0;
        end else if (en) begin
            r_out_q <= w_or;
            r_any_q <= |w_or;
        end
    end

    assign out_q = r_out_q;
    assign any_q = r_any_q;

`ifdef OR16_ACC_EN
    logic [15:0] r_acc;

    // Sticky OR-accumulator; clear wins over a simultaneous load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 16'h0000;
        end else if (acc_clr) begin
            r_acc <= 16'h0000;
        end else if (en) begin
            r_acc <= r_acc | w_or;
        end
    end

    assign acc = r_acc;
`else
    logic w_unused_acc_clr;

    assign w_unused_acc_clr = acc_clr;
    assign acc              = 16'h0000;
`endif

endmodule

// File: tb/tb_or_16.sv
// tb_or_16: directed, table-driven checks of or_16 combinational path,
// registered stage, accumulator and asynchronous reset.
module tb_or_16;

`ifdef OR16_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic [15:0] out;
    logic [15:0] a;
    logic [15:0] b;
    logic        clk;
    logic        rst;
    logic        en;
    logic        acc_clr;
    logic [15:0] out_q;
    logic        any_q;
    logic [15:0] acc;

    int n_cmp;
    int n_bad;

    or_16 dut (
        .out     (out),
        .a       (a),
        .b       (b),
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .acc_clr (acc_clr),
        .out_q   (out_q),
        .any_q   (any_q),
        .acc     (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
    } comb_vec_t;

    typedef struct {
        logic        en;
        logic        clr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        any;
        logic [15:0] acc;
    } seq_vec_t;

    comb_vec_t cv[4];
    seq_vec_t  sv[11];

    task automatic check16(input string name, input logic [15:0] act,
                           input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act,
                          input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [15:0] eacc(input logic [15:0] v);
        return ACC ? v : 16'h0000;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        cv[0] = '{16'h046A, 16'hDE57, 16'hDE7F};
        cv[1] = '{16'h2F2E, 16'hF6D8, 16'hFFFE};
        cv[2] = '{16'h0000, 16'h0000, 16'h0000};
        cv[3] = '{16'hA5A5, 16'h5A5A, 16'hFFFF};

        sv[0]  = '{1'b1, 1'b0, 16'h10C0, 16'hD76B, 16'hD7EB, 1'b1, 16'hD7EB};
        sv[1]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hD7EB, 1'b1, 16'hD7EB};
        sv[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hD7EB};
        sv[3]  = '{1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h0000};
        sv[4]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h0001};
        sv[5]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0100, 1'b1, 16'h0101};
        sv[6]  = '{1'b1, 1'b0, 16'h0000, 16'h8000, 16'h8000, 1'b1, 16'h8101};
        sv[7]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h8000, 1'b1, 16'h8101};
        sv[8]  = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 16'h0000};
        sv[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'h0000};
        sv[10] = '{1'b1, 1'b0, 16'h00F0, 16'h0000, 16'h00F0, 1'b1, 16'h00F0};

        rst     = 1'b1;
        en      = 1'b1;
        acc_clr = 1'b0;
        a       = 16'h0F0F;
        b       = 16'h0000;
        #2;
        check16("reset_out_q", out_q, 16'h0000);
        check1 ("reset_any_q", any_q, 1'b0);
        check16("reset_acc", acc, 16'h0000);
        @(posedge clk);
        #1;
        check16("reset_hold_out_q", out_q, 16'h0000);
        check16("reset_out_comb", out, 16'h0F0F);

        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = cv[i].a;
            b = cv[i].b;
            #1;
            check16($sformatf("comb[%0d]", i), out, cv[i].out);
        end

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            en      = sv[i].en;
            acc_clr = sv[i].clr;
            a       = sv[i].a;
            b       = sv[i].b;
            @(posedge clk);
            #1;
            check16($sformatf("seq[%0d].out_q", i), out_q, sv[i].q);
            check1 ($sformatf("seq[%0d].any_q", i), any_q, sv[i].any);
            check16($sformatf("seq[%0d].acc", i), acc, eacc(sv[i].acc));
        end

        @(negedge clk);
        #2;
        en      = 1'b1;
        acc_clr = 1'b0;
        a       = 16'h1234;
        b       = 16'h0100;
        rst     = 1'b1;
        #1;
        check16("arst_out_q", out_q, 16'h0000);
        check1 ("arst_any_q", any_q, 1'b0);
        check16("arst_acc", acc, 16'h0000);
        check16("arst_out_comb", out, 16'h1334);
        @(posedge clk);
        #1;
        check16("arst_edge_out_q", out_q, 16'h0000);
        check16("arst_edge_acc", acc, 16'h0000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check16("release_out_q", out_q, 16'h1334);
        check1 ("release_any_q", any_q, 1'b1);
        check16("release_acc", acc, eacc(16'h1334));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
